delay_timer_arbiter: RTL

Shares one prescaled down-counting delay timer among `NREQ` requesters under round-robin arbitration. A requester raises a level request with its delay value. The arbiter grants the timer and loads the delay. It then counts prescaled ticks and pulses that requester's `done` on expiry. It serves the pipeline-stall, peripheral-wait and debounce paths in the CPU so they do not each need their own counter.

---
 rtl/delay_timer_arbiter_if.sv | 22 ++
 rtl/delay_timer_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/delay_timer_arbiter_if.sv
// Requester <-> shared delay timer bus.
//   req       : level request per requester, held until done or abort
//   dly       : packed per-requester delays, requester i at [i*DW +: DW]
//   gnt       : one-hot owner of the timer
//   done      : one-clock expiry pulse to the owner
//   busy      : timer not idle
//   remaining : current down-count value
// master = requester side, slave = timer side.
interface delay_timer_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] dly;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [DW-1:0]      remaining;

  modport master (output req, dly, input gnt, done, busy, remaining);
  modport slave  (input req, dly, output gnt, done, busy, remaining);
endinterface

// File: rtl/delay_timer_arbiter.sv
// One prescaled down-counting delay timer shared by NREQ requesters under
// round-robin arbitration. The winner's delay is loaded at grant, counted
// down once per prescaler tick, and the owner gets a one-clock done pulse
// on expiry. Dropping req while owning aborts silently.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : delay_timer_arbiter_if.slave (req/dly in; gnt/done/busy/remaining out)
// All outputs are registered.
module delay_timer_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int PRE_MAX = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  delay_timer_arbiter_if.slave bus
);

  localparam int PW = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic [DW-1:0]   rem_q;
  logic [PW-1:0]   pre_q;
  // Last granted index; while RUN/DONE this is also the current owner.
  logic [IW-1:0]   ptr_q;

  logic [NREQ-1:0][DW-1:0] dly_a;
  logic [IW-1:0]           win_d;
  logic                    win_vld_d;
  logic                    tick;
  logic                    own_req;

  assign dly_a   = bus.dly;
  assign tick    = (pre_q == PW'(PRE_MAX));
  assign own_req = bus.req[ptr_q];

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] k);
    logic [NREQ-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting just after the last winner, so the last
  // winner is considered last.
  always_comb begin
    int idx;
    idx       = 0;
    win_d     = '0;
    win_vld_d = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!win_vld_d && bus.req[IW'(idx)]) begin
        win_vld_d = 1'b1;
        win_d     = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      rem_q   <= '0;
      pre_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (win_vld_d) begin
            state_q <= RUN;
            gnt_q   <= onehot(win_d);
            busy_q  <= 1'b1;
            rem_q   <= dly_a[win_d];
            pre_q   <= '0;
            ptr_q   <= win_d;
          end else begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            rem_q  <= '0;
          end
        end
        RUN: begin
          // Abort beats expiry: an owner that has let go gets no done.
          if (!own_req) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
            pre_q   <= '0;
          end else if (rem_q == '0) begin
            state_q <= DONE;
            gnt_q   <= '0;
            done_q  <= onehot(ptr_q);
            busy_q  <= 1'b1;
          end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick) rem_q <= rem_q - DW'(1);
          end
        end
        DONE: begin
          // Always pass through IDLE so arbitration sees fresh req levels.
          state_q <= IDLE;
          done_q  <= '0;
          busy_q  <= 1'b0;
          gnt_q   <= '0;
          rem_q   <= '0;
          pre_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          rem_q   <= '0;
          pre_q   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.remaining = rem_q;

endmodule
